cfg_bank_arbiter: RTL
=====================

Name: cfg_bank_arbiter

Overview:
- Shares the single write/read port of the configuration register bank between two requesters.
- Requester A is the SPI register-interface write strobe. It cannot be stalled, so it is buffered in a 2-entry FIFO.
- Requester B is an on-chip local master using a valid/ready handshake, with read and write access.
- The block sits between the SPI register slave, the local control logic and the config register storage. It round-robins between A and B and performs one bank operation at a time.

Parameters:
NUM_CFG, 8, number of config registers in the bank
REG_WIDTH, 8, register data width
ADDR_W, 3, address width of both requesters (addresses >= NUM_CFG are invalid)

Ports:
clk  input  1  system clock, all logic on rising edge
rstb  input  1  synchronous active-low reset
ena  input  1  block enable; 0 freezes captures and new grants
a_wr_vld  input  1  single-cycle write strobe from SPI side
a_addr  input  ADDR_W  SPI write address
a_wdata  input  REG_WIDTH  SPI write data
b_vld  input  1  local request valid
b_rdy  output  1  local request accepted this cycle
b_we  input  1  1=write, 0=read
b_addr  input  ADDR_W  local address
b_wdata  input  REG_WIDTH  local write data
b_rdata  output  REG_WIDTH  local read data
b_rdata_vld  output  1  one-cycle pulse, b_rdata valid
bank_we  output  1  bank write enable (registered)
bank_addr  output  ADDR_W  bank address (registered)
bank_wdata  output  REG_WIDTH  bank write data (registered)
bank_rdata  input  REG_WIDTH  bank read data, combinational from bank_addr
a_ovf  output  1  sticky: SPI write dropped because FIFO full
addr_err  output  1  one-cycle pulse: granted op had address >= NUM_CFG
ovf_clr  input  1  clears a_ovf

Behaviour:
- Reset is synchronous, taken when rstb=0 at a clk edge. It has priority over everything, including an in-flight op.
- Reset values: every output is 0, FIFO is empty, state=IDLE, last_grant=B (so A wins the first tie).
- A FIFO: 2 entries holding {addr,data}.
  - Push when a_wr_vld=1 and ena=1.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the write is dropped and a_ovf is set the next cycle.
  - ovf_clr=1 clears a_ovf next cycle. If a set and a clear occur in the same cycle, the set wins.
- FSM states: IDLE and BUSY.
  - In IDLE with ena=1, grant selection:
    - A nonempty and b_vld=0: grant A.
    - b_vld=1 and A empty: grant B.
    - Both pending: grant the requester that is not last_grant.
  - On grant A: pop the FIFO head. On grant B: b_rdy=1 this cycle (combinational; b_rdy is 0 in all other cases). Update last_grant, then go to BUSY.
  - BUSY lasts exactly one cycle, then returns to IDLE. Peak throughput is one operation per 2 cycles.
- Bank timing: the decision is made in cycle N.
  - bank_addr, bank_wdata and bank_we are driven from registers in cycle N+1.
  - bank_we is a 1-cycle pulse for writes.
  - bank_addr holds its last value when idle. bank_wdata holds when idle.
- B read: in cycle N+1, bank_rdata is sampled into b_rdata. b_rdata_vld=1 in cycle N+2 for one cycle. b_rdata holds until the next read.
- Invalid address (>= NUM_CFG):
  - bank_we stays 0.
  - A read returns b_rdata=0, still with b_rdata_vld in N+2.
  - addr_err pulses in cycle N+1.
  - The op still consumes its grant and BUSY cycle.
- ena=0:
  - No FIFO pushes. The a_wr_vld strobe is ignored and does not set a_ovf.
  - No new grants; b_rdy=0.
  - An op already in BUSY completes, including its read-data return.
  - FIFO contents are retained.
- b_addr, b_we and b_wdata are sampled only in the cycle b_rdy=1. The requester must hold them stable while b_vld=1.

Test Plan:
- Reset, then A writes (addr 2, 0x5A) -> bank_we pulses 2 cycles after the strobe's push with bank_addr=2 and bank_wdata=0x5A; all other outputs are 0 throughout.
- b_vld held with continuous A strobes, alternating b_we write (addr 1, 0x33) and read (addr 1) -> grants alternate A,B,A,B (A first after reset); the B read returns 0x33 with b_rdata_vld exactly 2 cycles after b_rdy.
- Three A strobes on consecutive cycles while B holds the bank -> the first two are buffered, the third is dropped and a_ovf=1; ovf_clr then clears it; the two buffered writes commit in order.
- B read of address 9 with ADDR_W=4, NUM_CFG=8 -> addr_err pulses, bank_we=0, b_rdata=0 with b_rdata_vld.
- ena dropped while the FIFO holds 1 entry and B is pending -> no grants and b_rdy=0; raising ena grants A first (last_grant=B).
- rstb=0 asserted during BUSY with a read in flight -> no b_rdata_vld, FIFO empty, a_ovf=0 after the next edge.

Source files
------------

// File: rtl/cfg_bank_arbiter_if.sv
// Bus bundle for cfg_bank_arbiter.
// Carries the SPI write strobe (A), the local valid/ready requester (B) and
// the registered config-bank port.
//   slave  : the arbiter side. It takes A/B requests and bank read data, and
//            drives b_rdy, the read return and the bank port.
//   master : the environment side. This is the requesters plus the bank storage.
interface cfg_bank_arbiter_if #(
  parameter int ADDR_W    = 3,
  parameter int REG_WIDTH = 8
);
  // Requester A: SPI write strobe (cannot be stalled)
  logic                 a_wr_vld;
  logic [ADDR_W-1:0]    a_addr;
  logic [REG_WIDTH-1:0] a_wdata;
  // Requester B: local master, valid/ready, read or write
  logic                 b_vld;
  logic                 b_rdy;
  logic                 b_we;
  logic [ADDR_W-1:0]    b_addr;
  logic [REG_WIDTH-1:0] b_wdata;
  logic [REG_WIDTH-1:0] b_rdata;
  logic                 b_rdata_vld;
  // Config bank port
  logic                 bank_we;
  logic [ADDR_W-1:0]    bank_addr;
  logic [REG_WIDTH-1:0] bank_wdata;
  logic [REG_WIDTH-1:0] bank_rdata;

  modport slave (
    input  a_wr_vld, a_addr, a_wdata,
    input  b_vld, b_we, b_addr, b_wdata,
    output b_rdy, b_rdata, b_rdata_vld,
    output bank_we, bank_addr, bank_wdata,
    input  bank_rdata
  );

  modport master (
    output a_wr_vld, a_addr, a_wdata,
    output b_vld, b_we, b_addr, b_wdata,
    input  b_rdy, b_rdata, b_rdata_vld,
    input  bank_we, bank_addr, bank_wdata,
    output bank_rdata
  );
endinterface

// File: rtl/cfg_bank_arbiter.sv
// cfg_bank_arbiter: shares the single port of the config register bank
// between the SPI write strobe (A) and a local valid/ready master (B).
// A is buffered in a 2-entry FIFO. Grants alternate round-robin when both
// requesters are pending. Each operation takes one IDLE decision cycle and
// one BUSY cycle.
// Ports:
//   clk, rstb : clock and synchronous active-low reset
//   ena       : block enable; low blocks FIFO pushes and new grants
//   ovf_clr   : clears the sticky a_ovf flag
//   a_ovf     : sticky flag, set when an SPI write was dropped on a full FIFO
//   addr_err  : one-cycle pulse when a granted op addressed a register >= NUM_CFG
//   bus       : A/B requester and bank signals (slave modport)
module cfg_bank_arbiter #(
  parameter int NUM_CFG   = 8,
  parameter int REG_WIDTH = 8,
  parameter int ADDR_W    = 3
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                ena,
  input  logic                ovf_clr,
  output logic                a_ovf,
  output logic                addr_err,
  cfg_bank_arbiter_if.slave   bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BUSY  = 1'b1;
  localparam logic       GNT_A = 1'b0;
  localparam logic       GNT_B = 1'b1;

  logic [0:0]           state;
  logic                 last_grant;

  logic [ADDR_W-1:0]    fifo_addr [2];
  logic [REG_WIDTH-1:0] fifo_data [2];
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [1:0]           fifo_cnt;

  // The read return stages: a granted B read is marked here in N+1. The
  // bank data is then captured so that it shows up as b_rdata in N+2.
  logic                 rd_pend;
  logic                 rd_inv;

  logic                 grant_a;
  logic                 grant_b;
  logic                 gnt_any;
  logic                 gnt_we;
  logic                 gnt_inv;
  logic [ADDR_W-1:0]    gnt_addr;
  logic [REG_WIDTH-1:0] gnt_wdata;
  logic                 push_req;
  logic                 push;
  logic                 drop;

  // NOTE: every signal gets a default at the top of always_comb, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == IDLE && ena) begin
      // On a tie the grant goes to the requester that was not served last.
      if (fifo_cnt != 2'd0 && (!bus.b_vld || last_grant == GNT_B)) begin
        grant_a = 1'b1;
      end else if (bus.b_vld) begin
        grant_b = 1'b1;
      end
    end

    gnt_any   = grant_a || grant_b;
    gnt_we    = grant_a || bus.b_we;
    gnt_addr  = grant_a ? fifo_addr[rd_ptr] : bus.b_addr;
    gnt_wdata = grant_a ? fifo_data[rd_ptr] : bus.b_wdata;
    gnt_inv   = 32'(gnt_addr) >= 32'(NUM_CFG);

    // A full FIFO still accepts a write when its head leaves in the same
    // cycle. The freed slot is the one the write pointer already points to.
    push_req  = bus.a_wr_vld && ena;
    push      = push_req && (fifo_cnt != 2'd2 || grant_a);
    drop      = push_req && !push;
  end

  assign bus.b_rdy = grant_b;

  // NOTE: the FIFO storage is not reset. The occupancy count alone decides
  // which entries are valid, so the data flops need no reset path.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.a_addr;
      fifo_data[wr_ptr] <= bus.a_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples values from before the edge, whatever order the lines are in.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state           <= IDLE;
      last_grant      <= GNT_B;
      rd_ptr          <= 1'b0;
      wr_ptr          <= 1'b0;
      fifo_cnt        <= 2'd0;
      a_ovf           <= 1'b0;
      addr_err        <= 1'b0;
      rd_pend         <= 1'b0;
      rd_inv          <= 1'b0;
      bus.bank_we     <= 1'b0;
      bus.bank_addr   <= '0;
      bus.bank_wdata  <= '0;
      bus.b_rdata     <= '0;
      bus.b_rdata_vld <= 1'b0;
    end else begin
      if (push)    wr_ptr <= ~wr_ptr;
      if (grant_a) rd_ptr <= ~rd_ptr;
      case ({push, grant_a})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: ;
      endcase

      // If a drop and a clear happen in the same cycle, the drop wins.
      if (drop)         a_ovf <= 1'b1;
      else if (ovf_clr) a_ovf <= 1'b0;

      // BUSY always lasts exactly one cycle, even while ena is low.
      state <= gnt_any ? BUSY : IDLE;

      if (gnt_any) begin
        last_grant    <= grant_b ? GNT_B : GNT_A;
        bus.bank_addr <= gnt_addr;
        if (gnt_we) bus.bank_wdata <= gnt_wdata;
      end
      bus.bank_we <= gnt_any && gnt_we && !gnt_inv;
      addr_err    <= gnt_any && gnt_inv;

      rd_pend         <= grant_b && !bus.b_we;
      rd_inv          <= gnt_inv;
      bus.b_rdata_vld <= rd_pend;
      if (rd_pend) bus.b_rdata <= rd_inv ? '0 : bus.bank_rdata;
    end
  end

endmodule
